// File: rtl/tdm_demux_rx.sv
// rtl/tdm_demux_rx.sv - 4-slot TDM receive demultiplexer with frame lock (optional TDM_PARITY_EN)
module tdm_demux_rx #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ANCHO-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
`ifdef TDM_PARITY_EN
    input  logic             din_par,
    output logic             par_err,
`endif
    output logic [ANCHO-1:0] out0,
    output logic [ANCHO-1:0] out1,
    output logic [ANCHO-1:0] out2,
    output logic [ANCHO-1:0] out3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [1:0]       slot_d;
    logic [ANCHO-1:0] cap [4];
    logic             cap_en;
    logic [1:0]       cap_idx;
    logic             load_out;
    logic             sync_err_d;
    logic             bad;
    logic             bad_d;
    logic             beat_err;

`ifdef TDM_PARITY_EN
    logic par_err_d;
    assign beat_err = din_par ^ (^din);
`else
    assign beat_err = 1'b0;
`endif

    assign locked = (state == LOCKED);

    always_comb begin
        state_d    = state;
        slot_d     = slot;
        cap_en     = 1'b0;
        cap_idx    = 2'd0;
        load_out   = 1'b0;
        sync_err_d = 1'b0;
        bad_d      = bad;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (sof) begin
                        cap_en  = 1'b1;
                        slot_d  = 2'd1;
                        state_d = LOCKED;
                        bad_d   = beat_err;
                    end
                end
                LOCKED: begin
                    if (sof) begin
                        // A marker always restarts the frame; mid-frame it is a resync.
                        cap_en     = 1'b1;
                        slot_d     = 2'd1;
                        bad_d      = beat_err;
                        sync_err_d = (slot != 2'd0);
                    end else if (slot == 2'd0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        bad_d      = 1'b0;
                    end else begin
                        cap_en  = 1'b1;
                        cap_idx = slot;
                        slot_d  = slot + 2'd1;
                        bad_d   = bad | beat_err;
                        if (slot == 2'd3) begin
                            load_out = ~(bad | beat_err);
                            bad_d    = 1'b0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

`ifdef TDM_PARITY_EN
    assign par_err_d = cap_en & beat_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= 2'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            bad         <= 1'b0;
            out0        <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            for (int i = 0; i < 4; i++) cap[i] <= '0;
`ifdef TDM_PARITY_EN
            par_err     <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            slot        <= slot_d;
            frame_valid <= load_out;
            sync_err    <= sync_err_d;
            bad         <= bad_d;
            if (cap_en) cap[cap_idx] <= din;
            // Slot 3 goes straight from din so the whole frame lands on one edge.
            if (load_out) begin
                out0 <= cap[0];
                out1 <= cap[1];
                out2 <= cap[2];
                out3 <= din;
            end
`ifdef TDM_PARITY_EN
            par_err     <= par_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb/tb_tdm_demux_rx.sv - scoreboard bench for tdm_demux_rx
module tb_tdm_demux_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] out0, out1, out2, out3;
    logic       frame_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;
`ifdef TDM_PARITY_EN
    logic       din_par = 1'b0;
    logic       par_err;
    logic       par_flip = 1'b0;
`endif

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          fv_cyc = -1;
    int          t0;
    logic [31:0] sb_q[$];

    tdm_demux_rx #(.ANCHO(8)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .sof(sof),
`ifdef TDM_PARITY_EN
        .din_par(din_par),
        .par_err(par_err),
`endif
        .out0(out0),
        .out1(out1),
        .out2(out2),
        .out3(out3),
        .frame_valid(frame_valid),
        .slot(slot),
        .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Delivered frames are popped from the scoreboard one sample after the edge.
    always @(posedge clk) begin
        #1;
        if (frame_valid === 1'b1) begin
            fv_cyc = cyc;
            if (sb_q.size() == 0) check("fv_unexpected", 32'd1, 32'd0);
            else check("frame", {out3, out2, out1, out0}, sb_q.pop_front());
        end
    end

    task automatic beat(input logic s, input logic [7:0] d);
        din_valid = 1'b1;
        sof = s;
        din = d;
`ifdef TDM_PARITY_EN
        din_par = (^d) ^ par_flip;
`endif
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        sb_q.push_back({d, c, b, a});
        beat(1'b1, a);
        beat(1'b0, b);
        beat(1'b0, c);
        beat(1'b0, d);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        do_reset();
        check("rst_out", {out3, out2, out1, out0}, 32'h0);
        check("rst_locked", locked, 1'b0);
        check("rst_slot", slot, 2'd0);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_serr", sync_err, 1'b0);

        // Basic frame and latency
        sb_q.push_back(32'h44332211);
        beat(1'b1, 8'h11);
        t0 = cyc;
        check("sof_locked", locked, 1'b1);
        check("sof_slot", slot, 2'd1);
        beat(1'b0, 8'h22);
        beat(1'b0, 8'h33);
        beat(1'b0, 8'h44);
        check("f1_fv", frame_valid, 1'b1);
        check("f1_locked", locked, 1'b1);
        check("f1_slot", slot, 2'd0);
        idle(1);
        check("f1_fv_pulse", frame_valid, 1'b0);
        check("f1_lat", fv_cyc - t0, 32'd3);

        // Stalls between slot 1 and slot 2
        sb_q.push_back(32'h44332211);
        beat(1'b1, 8'h11);
        t0 = cyc;
        beat(1'b0, 8'h22);
        idle(3);
        check("stall_slot", slot, 2'd2);
        check("stall_fv", frame_valid, 1'b0);
        beat(1'b0, 8'h33);
        beat(1'b0, 8'h44);
        idle(1);
        check("stall_lat", fv_cyc - t0, 32'd6);

        // Hunting ignores beats without sof
        do_reset();
        beat(1'b0, 8'hAA);
        check("hunt_serr", sync_err, 1'b0);
        beat(1'b0, 8'hBB);
        check("hunt_locked", locked, 1'b0);
        check("hunt_serr2", sync_err, 1'b0);
        check("hunt_out", {out3, out2, out1, out0}, 32'h0);
        frame(8'h01, 8'h02, 8'h03, 8'h04);
        idle(1);

        // Resync mid-frame: partial frame discarded, outputs hold
        sb_q.push_back(32'h88776655);
        beat(1'b1, 8'h99);
        beat(1'b0, 8'h9A);
        beat(1'b1, 8'h55);
        check("resync_serr", sync_err, 1'b1);
        check("resync_slot", slot, 2'd1);
        check("resync_hold", {out3, out2, out1, out0}, 32'h04030201);
        beat(1'b0, 8'h66);
        check("resync_serr_1cyc", sync_err, 1'b0);
        beat(1'b0, 8'h77);
        beat(1'b0, 8'h88);
        idle(1);

        // Resync on the slot-3 position: sof wins, no delivery
        sb_q.push_back(32'h94939291);
        beat(1'b1, 8'hC1);
        beat(1'b0, 8'hC2);
        beat(1'b0, 8'hC3);
        beat(1'b1, 8'h91);
        check("rs3_serr", sync_err, 1'b1);
        check("rs3_fv", frame_valid, 1'b0);
        check("rs3_locked", locked, 1'b1);
        beat(1'b0, 8'h92);
        beat(1'b0, 8'h93);
        beat(1'b0, 8'h94);
        idle(1);

        // Back-to-back frames: one delivery every 4 cycles
        frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        t0 = fv_cyc;
        frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        idle(1);
        check("b2b_gap", fv_cyc - t0, 32'd4);

        // Lost sync at slot 0
        beat(1'b0, 8'h5A);
        check("lost_serr", sync_err, 1'b1);
        check("lost_locked", locked, 1'b0);
        check("lost_slot", slot, 2'd0);
        idle(1);
        check("lost_serr_1cyc", sync_err, 1'b0);

        // Reset mid-frame has priority over a valid sof beat
        beat(1'b1, 8'hE1);
        beat(1'b0, 8'hE2);
        rst = 1'b1;
        din_valid = 1'b1;
        sof = 1'b1;
        din = 8'hFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        din_valid = 1'b0;
        sof = 1'b0;
        check("mrst_out", {out3, out2, out1, out0}, 32'h0);
        check("mrst_locked", locked, 1'b0);
        check("mrst_slot", slot, 2'd0);
        check("mrst_fv", frame_valid, 1'b0);
        beat(1'b0, 8'h12);
        check("mrst_needsof", locked, 1'b0);
        frame(8'h31, 8'h32, 8'h33, 8'h34);
        idle(1);

`ifdef TDM_PARITY_EN
        beat(1'b1, 8'h21);
        beat(1'b0, 8'h22);
        par_flip = 1'b1;
        beat(1'b0, 8'h23);
        par_flip = 1'b0;
        check("par_err", par_err, 1'b1);
        beat(1'b0, 8'h24);
        check("par_err_1cyc", par_err, 1'b0);
        check("par_fv", frame_valid, 1'b0);
        check("par_hold", {out3, out2, out1, out0}, 32'h34333231);
        check("par_locked", locked, 1'b1);
        frame(8'h41, 8'h42, 8'h43, 8'h44);
        idle(1);
`endif

        idle(2);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
